ft_cmd_decoder: RTL and testbench

Host-command decoder sitting directly downstream of the FT245 receive path: pops bytes from the RX FIFO the FT245 interface fills, parses fixed-format command packets, and applies them to a bank of 16-bit control registers for the CCD sequencer. Read commands produce a 3-byte reply pushed into the TX FIFO that the FT245 interface drains back to the host. Malformed, out-of-range or stalled packets are dropped and counted.

---
 rtl/ft_cmd_decoder_pkg.sv | 62 ++++++
 rtl/ft_cmd_regfile.sv | 65 ++++++
 rtl/ft_cmd_decoder.sv | 191 +++++++++++++++++++
 tb/tb_ft_cmd_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/ft_cmd_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ft_cmd_decoder_pkg
// Description : Shared definitions for the FT245 host-command decoder:
//               default sync byte, opcode values, reply headers, FSM state
//               encoding and the opcode decode helper.
// Revision    : 1.0  initial release
// ============================================================================
package ft_cmd_decoder_pkg;

    localparam logic [7:0] c_SYNC_DEFAULT = 8'hA5;

    localparam logic [7:0] c_OPC_WRITE = 8'h01;
    localparam logic [7:0] c_OPC_READ  = 8'h02;
    localparam logic [7:0] c_OPC_START = 8'h03;
    localparam logic [7:0] c_OPC_CLEAR = 8'h04;

    localparam logic [7:0] c_HDR_OK  = 8'h5A;
    localparam logic [7:0] c_HDR_ERR = 8'hEE;

    typedef enum logic [3:0] {
        S_HUNT = 4'd0,
        S_OPC  = 4'd1,
        S_ADDR = 4'd2,
        S_DHI  = 4'd3,
        S_DLO  = 4'd4,
        S_EXEC = 4'd5,
        S_RPL0 = 4'd6,
        S_RPL1 = 4'd7,
        S_RPL2 = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_START = 2'd2,
        OP_CLEAR = 2'd3
    } op_t;

    typedef struct packed {
        logic valid;
        op_t  op;
    } opc_dec_t;

    // Maps a raw opcode byte onto the internal operation; valid is low for
    // anything that is not a known opcode (including a repeated sync byte).
    function automatic opc_dec_t decode_opc(input logic [7:0] b);
        opc_dec_t d;
        d.valid = 1'b1;
        d.op    = OP_WRITE;
        case (b)
            c_OPC_WRITE: d.op = OP_WRITE;
            c_OPC_READ:  d.op = OP_READ;
            c_OPC_START: d.op = OP_START;
            c_OPC_CLEAR: d.op = OP_CLEAR;
            default:     d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ft_cmd_regfile.sv
`default_nettype none
// ============================================================================
// Module      : ft_cmd_regfile
// Description : Bank of NREGS 16-bit control registers with a single write
//               port, registered one-hot write strobe, address range flag and
//               combinational read of the addressed register.
// Ports       : clk, rst_n       clock, synchronous active-low reset
//               i_wr_en          write request (ignored when out of range)
//               i_addr           register address byte
//               i_wr_data        data to write
//               o_in_range       i_addr < NREGS
//               o_rd_data        contents of register i_addr (0 if out of range)
//               o_reg_q          flat register contents, reg i at [16i+15:16i]
//               o_wr_strobe      one-cycle pulse on the register just written
// Revision    : 1.0  initial release
// ============================================================================
module ft_cmd_regfile #(
    parameter int NREGS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [7:0]            i_addr,
    input  logic [15:0]           i_wr_data,
    output logic                  o_in_range,
    output logic [15:0]           o_rd_data,
    output logic [NREGS*16-1:0]   o_reg_q,
    output logic [NREGS-1:0]      o_wr_strobe
);

    logic [NREGS*16-1:0] r_reg_q;
    logic [NREGS-1:0]    r_wr_strobe;
    logic                w_wr_ok;

    assign o_in_range = (i_addr < 8'(NREGS));
    assign w_wr_ok    = i_wr_en & o_in_range;

    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_reg_q[16*i +: 16] <= 16'h0000;
                r_wr_strobe[i]      <= 1'b0;
            end else begin
                r_wr_strobe[i] <= w_wr_ok && (i_addr == 8'(i));
                if (w_wr_ok && (i_addr == 8'(i))) begin
                    r_reg_q[16*i +: 16] <= i_wr_data;
                end
            end
        end
    end

    always_comb begin
        o_rd_data = 16'h0000;
        for (int k = 0; k < NREGS; k++) begin
            if (i_addr == 8'(k)) begin
                o_rd_data = r_reg_q[16*k +: 16];
            end
        end
    end

    assign o_reg_q     = r_reg_q;
    assign o_wr_strobe = r_wr_strobe;

endmodule
`default_nettype wire

// File: rtl/ft_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : ft_cmd_decoder
// Description : Pops command packets (SYNC, opcode, args) from an FWFT RX
//               FIFO, applies WRITE/READ/START/CLEAR_ERR to a control
//               register bank and pushes 3-byte read replies to a TX FIFO.
//               Bad opcodes, out-of-range addresses and stalled packets are
//               dropped and counted in a saturating error counter.
// Ports       : clk, rst_n                  clock, synchronous active-low reset
//               rx_rempty/rx_rdata/rx_rinc  RX FIFO read side (FWFT)
//               tx_wfull/tx_wdata/tx_winc   TX FIFO write side
//               reg_q, reg_wr_strobe        register contents and write pulses
//               start_pulse                 exposure start pulse
//               err_count                   saturating error counter
// Revision    : 1.0  initial release
// ============================================================================
module ft_cmd_decoder
    import ft_cmd_decoder_pkg::*;
#(
    parameter int         NREGS   = 8,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] SYNC    = c_SYNC_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_rempty,
    input  logic [7:0]           rx_rdata,
    output logic                 rx_rinc,
    input  logic                 tx_wfull,
    output logic [7:0]           tx_wdata,
    output logic                 tx_winc,
    output logic [NREGS*16-1:0]  reg_q,
    output logic [NREGS-1:0]     reg_wr_strobe,
    output logic                 start_pulse,
    output logic [7:0]           err_count
);

    localparam int TMO_W = $clog2(TIMEOUT) + 1;

    state_t           r_state, w_next;
    op_t              r_op;
    logic [7:0]       r_addr, r_dhi, r_dlo;
    logic [7:0]       r_rpl0, r_rpl1, r_rpl2;
    logic [TMO_W-1:0] r_tmo;
    logic [7:0]       r_err;
    logic             r_start;

    logic             w_byte_state, w_arg_state, w_rpl_state;
    logic             w_pop, w_push, w_tmo_hit;
    logic             w_err_inc, w_err_clr, w_wr_en, w_start;
    logic             w_in_range;
    logic [15:0]      w_rd_data;
    opc_dec_t         w_opc;

    assign w_byte_state = (r_state == S_HUNT) || (r_state == S_OPC) || (r_state == S_ADDR)
                       || (r_state == S_DHI)  || (r_state == S_DLO);
    assign w_arg_state  = w_byte_state && (r_state != S_HUNT);
    assign w_rpl_state  = (r_state == S_RPL0) || (r_state == S_RPL1) || (r_state == S_RPL2);

    assign w_pop     = rst_n & ~rx_rempty & w_byte_state;
    assign w_push    = rst_n & ~tx_wfull & w_rpl_state;
    assign w_tmo_hit = w_arg_state & rx_rempty & (r_tmo == TMO_W'(TIMEOUT - 1));
    assign w_opc     = decode_opc(rx_rdata);

    assign rx_rinc = w_pop;
    assign tx_winc = w_push;

    always_comb begin
        tx_wdata = 8'h00;
        if (rst_n) begin
            case (r_state)
                S_RPL0:  tx_wdata = r_rpl0;
                S_RPL1:  tx_wdata = r_rpl1;
                S_RPL2:  tx_wdata = r_rpl2;
                default: tx_wdata = 8'h00;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        w_err_inc = 1'b0;
        w_err_clr = 1'b0;
        w_wr_en   = 1'b0;
        w_start   = 1'b0;
        case (r_state)
            S_HUNT: if (w_pop && rx_rdata == SYNC) w_next = S_OPC;
            S_OPC: begin
                if (w_pop) begin
                    if (!w_opc.valid) begin
                        w_next    = S_HUNT;
                        w_err_inc = 1'b1;
                    end else if (w_opc.op == OP_WRITE || w_opc.op == OP_READ) begin
                        w_next = S_ADDR;
                    end else begin
                        w_next = S_EXEC;
                    end
                end
            end
            S_ADDR: if (w_pop) w_next = (r_op == OP_WRITE) ? S_DHI : S_EXEC;
            S_DHI:  if (w_pop) w_next = S_DLO;
            S_DLO:  if (w_pop) w_next = S_EXEC;
            S_EXEC: begin
                w_next = S_HUNT;
                case (r_op)
                    OP_WRITE: begin
                        w_wr_en   = 1'b1;
                        w_err_inc = ~w_in_range;
                    end
                    OP_READ: begin
                        w_next    = S_RPL0;
                        w_err_inc = ~w_in_range;
                    end
                    OP_START: w_start   = 1'b1;
                    default:  w_err_clr = 1'b1;
                endcase
            end
            S_RPL0: if (w_push) w_next = S_RPL1;
            S_RPL1: if (w_push) w_next = S_RPL2;
            S_RPL2: if (w_push) w_next = S_HUNT;
            default: w_next = S_HUNT;
        endcase
        // A timeout only fires on an empty cycle, so it never collides with a pop.
        if (w_tmo_hit) begin
            w_next    = S_HUNT;
            w_err_inc = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_HUNT;
            r_op    <= OP_WRITE;
            r_addr  <= 8'h00;
            r_dhi   <= 8'h00;
            r_dlo   <= 8'h00;
            r_rpl0  <= 8'h00;
            r_rpl1  <= 8'h00;
            r_rpl2  <= 8'h00;
            r_tmo   <= '0;
            r_err   <= 8'h00;
            r_start <= 1'b0;
        end else begin
            r_state <= w_next;
            r_start <= w_start;
            if (w_pop) begin
                case (r_state)
                    S_OPC:   r_op   <= w_opc.op;
                    S_ADDR:  r_addr <= rx_rdata;
                    S_DHI:   r_dhi  <= rx_rdata;
                    S_DLO:   r_dlo  <= rx_rdata;
                    default: ;
                endcase
            end
            if (w_pop || !w_arg_state) begin
                r_tmo <= '0;
            end else if (rx_rempty) begin
                r_tmo <= r_tmo + 1'b1;
            end
            if (r_state == S_EXEC && r_op == OP_READ) begin
                r_rpl0 <= w_in_range ? c_HDR_OK : c_HDR_ERR;
                r_rpl1 <= w_in_range ? w_rd_data[15:8] : 8'h00;
                r_rpl2 <= w_in_range ? w_rd_data[7:0]  : 8'h00;
            end
            if (w_err_clr) begin
                r_err <= 8'h00;
            end else if (w_err_inc && r_err != 8'hFF) begin
                r_err <= r_err + 8'h01;
            end
        end
    end

    ft_cmd_regfile #(
        .NREGS (NREGS)
    ) u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_wr_en     (w_wr_en),
        .i_addr      (r_addr),
        .i_wr_data   ({r_dhi, r_dlo}),
        .o_in_range  (w_in_range),
        .o_rd_data   (w_rd_data),
        .o_reg_q     (reg_q),
        .o_wr_strobe (reg_wr_strobe)
    );

    assign start_pulse = r_start;
    assign err_count   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ft_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ft_cmd_decoder
// Description : Directed self-checking bench for ft_cmd_decoder. Models the
//               RX FIFO (FWFT) and TX FIFO sink around the decoder.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ft_cmd_decoder;

    localparam int NREGS   = 8;
    localparam int TIMEOUT = 1024;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 rx_rempty = 1'b1;
    logic [7:0]           rx_rdata = 8'h00;
    logic                 rx_rinc;
    logic                 tx_wfull = 1'b0;
    logic [7:0]           tx_wdata;
    logic                 tx_winc;
    logic [NREGS*16-1:0]  reg_q;
    logic [NREGS-1:0]     reg_wr_strobe;
    logic                 start_pulse;
    logic [7:0]           err_count;

    ft_cmd_decoder #(.NREGS(NREGS), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_rempty(rx_rempty), .rx_rdata(rx_rdata), .rx_rinc(rx_rinc),
        .tx_wfull(tx_wfull), .tx_wdata(tx_wdata), .tx_winc(tx_winc),
        .reg_q(reg_q), .reg_wr_strobe(reg_wr_strobe),
        .start_pulse(start_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    int txcyc[$];
    int strobe_cnt = 0;
    logic [NREGS-1:0] strobe_last = '0;
    int start_cnt = 0;
    bit m_pop;

    task automatic rx_refresh();
        rx_rempty = (rxq.size() == 0);
        rx_rdata  = (rxq.size() == 0) ? 8'h00 : rxq[0];
    endtask

    task automatic push(input logic [7:0] b);
        rxq.push_back(b);
        rx_refresh();
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // FIFO models: sample handshakes at the edge, update FIFO state just after.
    always @(posedge clk) begin
        cyc = cyc + 1;
        m_pop = rx_rinc;
        if (tx_winc) begin
            txq.push_back(tx_wdata);
            txcyc.push_back(cyc);
        end
        #1;
        if (m_pop && rxq.size() > 0) void'(rxq.pop_front());
        rx_refresh();
    end

    always @(negedge clk) begin
        if (reg_wr_strobe != '0) begin
            strobe_cnt  = strobe_cnt + 1;
            strobe_last = reg_wr_strobe;
        end
        if (start_pulse) start_cnt = start_cnt + 1;
    end

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        push(8'hA5);
        cycles(2);
        total++; if (reg_q !== '0) begin bad++; $display("FAIL reset_reg_q got=%h want=0", reg_q); end
        total++; if (reg_wr_strobe !== '0) begin bad++; $display("FAIL reset_strobe got=%b want=0", reg_wr_strobe); end
        total++; if (start_pulse !== 1'b0) begin bad++; $display("FAIL reset_start got=%b want=0", start_pulse); end
        total++; if (err_count !== 8'h00) begin bad++; $display("FAIL reset_err got=%0d want=0", err_count); end
        total++; if (rx_rinc !== 1'b0) begin bad++; $display("FAIL reset_rx_rinc got=%b want=0", rx_rinc); end
        total++; if (tx_winc !== 1'b0) begin bad++; $display("FAIL reset_tx_winc got=%b want=0", tx_winc); end
        total++; if (tx_wdata !== 8'h00) begin bad++; $display("FAIL reset_tx_wdata got=%h want=00", tx_wdata); end
        rxq.delete();
        rx_refresh();
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_write();
        strobe_cnt = 0;
        push(8'hA5); push(8'h01); push(8'h03); push(8'h12); push(8'h34);
        cycles(5);
        total++; if (reg_wr_strobe !== '0 || reg_q[16*3 +: 16] !== 16'h0000) begin
            bad++; $display("FAIL write_early strobe=%b reg3=%h want 0/0000", reg_wr_strobe, reg_q[16*3 +: 16]); end
        cycles(1);
        total++; if (reg_wr_strobe !== 8'b0000_1000) begin bad++; $display("FAIL write_strobe got=%b want=00001000", reg_wr_strobe); end
        total++; if (reg_q[16*3 +: 16] !== 16'h1234) begin bad++; $display("FAIL write_reg3 got=%h want=1234", reg_q[16*3 +: 16]); end
        cycles(1);
        total++; if (reg_wr_strobe !== '0) begin bad++; $display("FAIL write_strobe_off got=%b want=0", reg_wr_strobe); end
        total++; if (strobe_cnt !== 1) begin bad++; $display("FAIL write_strobe_len got=%0d want=1", strobe_cnt); end
        total++; if (err_count !== 8'h00) begin bad++; $display("FAIL write_err got=%0d want=0", err_count); end
        push(8'hA5); push(8'h01); push(8'h07); push(8'hA5); push(8'h5A);
        cycles(10);
        total++; if (reg_q[16*7 +: 16] !== 16'hA55A) begin bad++; $display("FAIL write_reg7 got=%h want=a55a", reg_q[16*7 +: 16]); end
        total++; if (strobe_last !== 8'b1000_0000 || strobe_cnt !== 2) begin
            bad++; $display("FAIL write_strobe7 got=%b cnt=%0d want=10000000 cnt=2", strobe_last, strobe_cnt); end
    endtask

    task automatic test_read();
        logic [23:0] got;
        txq.delete(); txcyc.delete();
        push(8'hA5); push(8'h02); push(8'h03);
        cycles(12);
        got = (txq.size() == 3) ? {txq[0], txq[1], txq[2]} : 24'hxxxxxx;
        total++; if (got !== 24'h5A1234) begin bad++; $display("FAIL read_reply got=%h n=%0d want=5a1234", got, txq.size()); end
        total++; if (txcyc.size() != 3 || txcyc[2] - txcyc[0] != 2) begin
            bad++; $display("FAIL read_consecutive got n=%0d want 3 consecutive pushes", txcyc.size()); end
        // Stalled TX: reply must be held, then delivered once without loss.
        txq.delete(); txcyc.delete();
        tx_wfull = 1'b1;
        push(8'hA5); push(8'h02); push(8'h07);
        cycles(13);
        total++; if (txq.size() != 0 || tx_winc !== 1'b0) begin
            bad++; $display("FAIL read_stall got n=%0d winc=%b want 0/0", txq.size(), tx_winc); end
        total++; if (tx_wdata !== 8'h5A) begin bad++; $display("FAIL read_stall_data got=%h want=5a", tx_wdata); end
        tx_wfull = 1'b0;
        cycles(6);
        got = (txq.size() == 3) ? {txq[0], txq[1], txq[2]} : 24'hxxxxxx;
        total++; if (got !== 24'h5AA55A) begin bad++; $display("FAIL read_stall_reply got=%h n=%0d want=5aa55a", got, txq.size()); end
        // Back-to-back write then read of the same register.
        txq.delete(); txcyc.delete();
        push(8'hA5); push(8'h01); push(8'h00); push(8'hBE); push(8'hEF);
        push(8'hA5); push(8'h02); push(8'h00);
        cycles(20);
        got = (txq.size() == 3) ? {txq[0], txq[1], txq[2]} : 24'hxxxxxx;
        total++; if (got !== 24'h5ABEEF) begin bad++; $display("FAIL b2b_reply got=%h n=%0d want=5abeef", got, txq.size()); end
    endtask

    task automatic test_errors();
        logic [23:0] got;
        int s0;
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h07);
        cycles(8);
        total++; if (err_count !== 8'd1) begin bad++; $display("FAIL err_badop got=%0d want=1", err_count); end
        s0 = strobe_cnt;
        push(8'hA5); push(8'h01); push(8'h09); push(8'h00); push(8'h01);
        cycles(10);
        total++; if (strobe_cnt != s0 || err_count !== 8'd2) begin
            bad++; $display("FAIL err_wr_range strobes=%0d err=%0d want=%0d/2", strobe_cnt, err_count, s0); end
        txq.delete();
        push(8'hA5); push(8'h02); push(8'h09);
        cycles(12);
        got = (txq.size() == 3) ? {txq[0], txq[1], txq[2]} : 24'hxxxxxx;
        total++; if (got !== 24'hEE0000 || err_count !== 8'd3) begin
            bad++; $display("FAIL err_rd_range got=%h err=%0d want=ee0000/3", got, err_count); end
        push(8'hA5); push(8'hA5);
        cycles(6);
        total++; if (err_count !== 8'd4) begin bad++; $display("FAIL err_sync_as_op got=%0d want=4", err_count); end
        push(8'hA5); push(8'h01); push(8'h08); push(8'h11); push(8'h22);
        cycles(10);
        total++; if (strobe_cnt != s0 || err_count !== 8'd5) begin
            bad++; $display("FAIL err_addr_eq_n strobes=%0d err=%0d want=%0d/5", strobe_cnt, err_count, s0); end
    endtask

    task automatic test_timeout();
        push(8'hA5); push(8'h01); push(8'h02);
        cycles(3 + TIMEOUT - 10);
        total++; if (err_count !== 8'd5) begin bad++; $display("FAIL tmo_early got=%0d want=5", err_count); end
        cycles(30);
        total++; if (err_count !== 8'd6) begin bad++; $display("FAIL tmo_fire got=%0d want=6", err_count); end
        start_cnt = 0;
        push(8'hA5); push(8'h03);
        cycles(6);
        total++; if (start_cnt != 1) begin bad++; $display("FAIL tmo_start got=%0d want=1", start_cnt); end
        total++; if (reg_q[16*2 +: 16] !== 16'h0000) begin bad++; $display("FAIL tmo_no_write got=%h want=0000", reg_q[16*2 +: 16]); end
    endtask

    task automatic test_reset_mid_reply();
        int i;
        txq.delete();
        push(8'hA5); push(8'h02); push(8'h07);
        for (i = 0; i < 20 && txq.size() < 1; i++) @(negedge clk);
        total++; if (txq.size() != 1) begin bad++; $display("FAIL rmr_first_byte got n=%0d want=1", txq.size()); end
        rst_n = 1'b0;
        cycles(2);
        total++; if (tx_winc !== 1'b0) begin bad++; $display("FAIL rmr_winc_in_reset got=%b want=0", tx_winc); end
        rst_n = 1'b1;
        cycles(8);
        total++; if (txq.size() != 1) begin bad++; $display("FAIL rmr_no_more got n=%0d want=1", txq.size()); end
        total++; if (reg_q !== '0 || err_count !== 8'd0) begin
            bad++; $display("FAIL rmr_cleared reg_q=%h err=%0d want 0/0", reg_q, err_count); end
        push(8'hA5); push(8'h04);
        cycles(6);
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL rmr_clear got=%0d want=0", err_count); end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 254; k++) begin push(8'hA5); push(8'h10); end
        cycles(520);
        total++; if (err_count !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d want=254", err_count); end
        for (int k = 0; k < 46; k++) begin push(8'hA5); push(8'h10); end
        cycles(100);
        total++; if (err_count !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d want=255", err_count); end
        push(8'hA5); push(8'h04);
        cycles(5);
        total++; if (err_count !== 8'd0) begin bad++; $display("FAIL sat_clear got=%0d want=0", err_count); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_errors();
        test_timeout();
        test_reset_mid_reply();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
`default_nettype wire
